// File: rtl/mdu_scheduler.sv
// -----------------------------------------------------------------------------
// mdu_scheduler
//
// Sequencing controller for the multiply/divide unit in the EX stage. It
// decodes the MD operation of the EX instruction and issues a one-cycle
// `start` pulse for the long ops (MULT/MULTU/DIV/DIVU). A latency counter
// times the running op and drives `busy` and `done`. `stall` holds a dependent
// MD instruction in ID until the unit is free. A flush suppresses issue of the
// EX instruction, but it never cancels an op that is already running.
//
// Parameters:
//   MULT_LAT  busy cycles for MULT/MULTU (1..15)
//   DIV_LAT   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   ex_md_op  in   MD opcode of the EX instruction (0 NONE, 1 MULT, 2 MULTU,
//                  3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9..15 NONE)
//   id_is_md  in   the ID instruction is an MD op
//   flush     in   the EX instruction is cancelled this cycle
//   start     out  combinational issue pulse for a long op
//   mdu_ctrl  out  combinational; the accepted opcode, otherwise 0
//   mthi_we   out  combinational HI write enable
//   mtlo_we   out  combinational LO write enable
//   busy      out  registered; a long op is in progress
//   done      out  combinational; high in the last busy cycle
//   stall     out  combinational; freezes PC and IF/ID and bubbles ID/EX
// -----------------------------------------------------------------------------
module mdu_scheduler #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ex_md_op,
  input  logic       id_is_md,
  input  logic       flush,
  output logic       start,
  output logic [3:0] mdu_ctrl,
  output logic       mthi_we,
  output logic       mtlo_we,
  output logic       busy,
  output logic       done,
  output logic       stall
);

  // ---------------------------------------------------------------------------
  // Opcode encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  // ---------------------------------------------------------------------------
  // Decode of the EX opcode. Codes 9..15 fall outside both ranges and so
  // behave exactly like NONE.
  // ---------------------------------------------------------------------------
  logic op_long;
  logic op_short;
  logic op_div;
  logic acc;

  assign op_long  = (ex_md_op >= MD_MULT) && (ex_md_op <= MD_DIVU);
  assign op_short = (ex_md_op >= MD_MTHI) && (ex_md_op <= MD_MFLO);
  assign op_div   = (ex_md_op == MD_DIV)  || (ex_md_op == MD_DIVU);

  // An op is only accepted from IDLE; while running, the stall keeps MD ops
  // out of EX, and anything that slips through is dropped here.
  assign acc = (op_long || op_short) && !flush && (state == IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so that no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (acc && op_long) begin
          state_next = RUN;
          cnt_next   = op_div ? DIV_CNT : MULT_CNT;
        end
      end
      RUN: begin
        // Counting down to 1 marks the final busy cycle; the decrement past
        // that point leaves cnt at 0 in IDLE.
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    start    = 1'b0;
    mdu_ctrl = MD_NONE;
    mthi_we  = 1'b0;
    mtlo_we  = 1'b0;
    if (acc) begin
      mdu_ctrl = ex_md_op;
      start    = op_long;
      mthi_we  = (ex_md_op == MD_MTHI);
      mtlo_we  = (ex_md_op == MD_MTLO);
    end
  end

  // busy is a decode of the state flop, so it carries no input-to-output path.
  assign busy = (state == RUN);
  assign done = busy && (cnt == 4'd1);

  // The stall covers the issue cycle as well as the busy cycles, so a
  // dependent MD op in ID cannot reach EX until the cycle after done.
  assign stall = id_is_md && (start || busy);

endmodule

// File: tb/tb_mdu_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mdu_scheduler
//
// Directed bench for mdu_scheduler. Inputs change 1 ns after each rising edge
// and outputs are checked on the falling edge, so every check observes one
// full "cycle" of the combinational outputs and the state that precedes the
// next edge. A second instance with MULT_LAT=1 / DIV_LAT=15 covers the
// latency range limits.
// -----------------------------------------------------------------------------
module tb_mdu_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] ex_md_op;
  logic       id_is_md;
  logic       flush;

  logic       start,   start_m;
  logic [3:0] mdu_ctrl, mdu_ctrl_m;
  logic       mthi_we, mthi_we_m;
  logic       mtlo_we, mtlo_we_m;
  logic       busy,    busy_m;
  logic       done,    done_m;
  logic       stall,   stall_m;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_scheduler #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .ex_md_op (ex_md_op),
    .id_is_md (id_is_md),
    .flush    (flush),
    .start    (start),
    .mdu_ctrl (mdu_ctrl),
    .mthi_we  (mthi_we),
    .mtlo_we  (mtlo_we),
    .busy     (busy),
    .done     (done),
    .stall    (stall)
  );

  mdu_scheduler #(.MULT_LAT(1), .DIV_LAT(15)) dut_lim (
    .clk      (clk),
    .reset    (reset),
    .ex_md_op (ex_md_op),
    .id_is_md (id_is_md),
    .flush    (flush),
    .start    (start_m),
    .mdu_ctrl (mdu_ctrl_m),
    .mthi_we  (mthi_we_m),
    .mtlo_we  (mtlo_we_m),
    .busy     (busy_m),
    .done     (done_m),
    .stall    (stall_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle: apply new inputs after the edge, then wait until the
  // falling edge where the outputs of that cycle are checked.
  task automatic cyc(input logic [3:0] op, input logic idmd, input logic fl, input logic rst);
    @(posedge clk);
    #1;
    ex_md_op = op;
    id_is_md = idmd;
    flush    = fl;
    reset    = rst;
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  busy,     1'b0);
    check({tag, ".start"}, start,    1'b0);
    check({tag, ".stall"}, stall,    1'b0);
    check({tag, ".done"},  done,     1'b0);
    check({tag, ".ctrl"},  mdu_ctrl, 4'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ex_md_op = 4'd0;
    id_is_md = 1'b0;
    flush    = 1'b0;

    // ---- Reset, then idle inputs ----
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'd0, 1'b0, 1'b0, 1'b0);
      check_idle($sformatf("idle%0d", i));
      check("idle.we", {30'd0, mthi_we, mtlo_we}, 32'd0);
    end

    // ---- MULT at T with a dependent MD op held in ID ----
    cyc(4'd1, 1'b1, 1'b0, 1'b0);                   // T
    check("mult.T.start", start,    1'b1);
    check("mult.T.ctrl",  mdu_ctrl, 4'd1);
    check("mult.T.stall", stall,    1'b1);
    check("mult.T.busy",  busy,     1'b0);
    check("lim.T.start",  start_m,  1'b1);
    for (int k = 1; k <= 5; k++) begin             // T+1 .. T+5
      cyc(4'd0, 1'b1, 1'b0, 1'b0);
      check($sformatf("mult.%0d.busy", k),  busy,  1'b1);
      check($sformatf("mult.%0d.done", k),  done,  (k == 5));
      check($sformatf("mult.%0d.stall", k), stall, 1'b1);
      check($sformatf("mult.%0d.start", k), start, 1'b0);
      check($sformatf("lim.%0d.busy", k),   busy_m, (k == 1));
      check($sformatf("lim.%0d.done", k),   done_m, (k == 1));
    end
    // T+6: the dependent MFHI reaches EX and is accepted; ID now non-MD.
    cyc(4'd7, 1'b0, 1'b0, 1'b0);
    check("mult.6.busy",  busy,     1'b0);
    check("mult.6.stall", stall,    1'b0);
    check("mult.6.ctrl",  mdu_ctrl, 4'd7);
    check("mult.6.start", start,    1'b0);

    // ---- Back-to-back MULTs: second issues at T+LAT+1 ----
    cyc(4'd1, 1'b1, 1'b0, 1'b0);                   // T
    check("b2b.T.start", start, 1'b1);
    for (int k = 1; k <= 5; k++) cyc(4'd0, 1'b1, 1'b0, 1'b0);
    check("b2b.5.done", done, 1'b1);
    cyc(4'd2, 1'b0, 1'b0, 1'b0);                   // T+6 MULTU
    check("b2b.6.start", start,    1'b1);
    check("b2b.6.ctrl",  mdu_ctrl, 4'd2);
    for (int k = 1; k <= 5; k++) cyc(4'd0, 1'b0, 1'b0, 1'b0);
    check("b2b.11.done", done, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    check("b2b.12.busy", busy, 1'b0);

    // ---- DIVU flushed at T, reissued at T+1 ----
    cyc(4'd4, 1'b1, 1'b1, 1'b0);                   // T, flushed
    check("divf.T.start", start,    1'b0);
    check("divf.T.ctrl",  mdu_ctrl, 4'd0);
    check("divf.T.stall", stall,    1'b0);
    check("divf.T.busy",  busy,     1'b0);
    cyc(4'd4, 1'b0, 1'b0, 1'b0);                   // T+1, issues
    check("divf.T1.start", start,    1'b1);
    check("divf.T1.ctrl",  mdu_ctrl, 4'd4);
    check("divf.T1.stall", stall,    1'b0);
    check("lim.div.start", start_m,  1'b1);
    for (int k = 1; k <= 16; k++) begin
      cyc(4'd0, 1'b0, 1'b0, 1'b0);
      check($sformatf("divf.%0d.busy", k), busy,   (k <= 10));
      check($sformatf("divf.%0d.done", k), done,   (k == 10));
      check($sformatf("lim.div%0d.busy", k), busy_m, (k <= 15));
      check($sformatf("lim.div%0d.done", k), done_m, (k == 15));
    end

    // ---- Short ops in IDLE ----
    cyc(4'd6, 1'b0, 1'b0, 1'b0);                   // MTLO
    check("mtlo.we_lo", mtlo_we,  1'b1);
    check("mtlo.we_hi", mthi_we,  1'b0);
    check("mtlo.ctrl",  mdu_ctrl, 4'd6);
    check("mtlo.start", start,    1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    check("mtlo.after", mtlo_we,  1'b0);
    check("mtlo.busy",  busy,     1'b0);
    cyc(4'd5, 1'b1, 1'b0, 1'b0);                   // MTHI with MD op in ID
    check("mthi.we_hi", mthi_we,  1'b1);
    check("mthi.we_lo", mtlo_we,  1'b0);
    check("mthi.ctrl",  mdu_ctrl, 4'd5);
    check("mthi.stall", stall,    1'b0);
    cyc(4'd7, 1'b0, 1'b0, 1'b0);                   // MFHI
    check("mfhi.ctrl", mdu_ctrl, 4'd7);
    check("mfhi.we",   {30'd0, mthi_we, mtlo_we}, 32'd0);
    check("mfhi.busy", busy, 1'b0);
    cyc(4'd8, 1'b0, 1'b1, 1'b0);                   // MFLO flushed
    check("mflo.flush.ctrl", mdu_ctrl, 4'd0);
    cyc(4'd12, 1'b1, 1'b0, 1'b0);                  // illegal code
    check("illegal.ctrl",  mdu_ctrl, 4'd0);
    check("illegal.start", start,    1'b0);
    check("illegal.stall", stall,    1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    check("illegal.busy", busy, 1'b0);

    // ---- DIV with flush pulsed at cnt=6 and an MD op dropped in RUN ----
    cyc(4'd3, 1'b0, 1'b0, 1'b0);                   // T
    check("divr.T.start", start,    1'b1);
    check("divr.T.ctrl",  mdu_ctrl, 4'd3);
    for (int k = 1; k <= 11; k++) begin
      if (k == 3)      cyc(4'd6, 1'b0, 1'b0, 1'b0);  // dropped in RUN
      else if (k == 5) cyc(4'd1, 1'b1, 1'b1, 1'b0);  // cnt=6, flush pulse
      else             cyc(4'd0, 1'b0, 1'b0, 1'b0);
      check($sformatf("divr.%0d.busy", k), busy, (k <= 10));
      check($sformatf("divr.%0d.done", k), done, (k == 10));
      if (k == 3) begin
        check("divr.drop.ctrl", mdu_ctrl, 4'd0);
        check("divr.drop.we",   mtlo_we,  1'b0);
      end
      if (k == 5) begin
        check("divr.flush.start", start, 1'b0);
        check("divr.flush.stall", stall, 1'b1);
      end
    end

    // ---- Reset asserted mid-DIV at T+3, MULT at T+5 ----
    cyc(4'd3, 1'b0, 1'b0, 1'b0);                   // T
    check("rdiv.T.start", start, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);                   // T+1
    cyc(4'd0, 1'b0, 1'b0, 1'b0);                   // T+2
    cyc(4'd0, 1'b0, 1'b0, 1'b1);                   // T+3 reset
    check("rdiv.3.busy", busy, 1'b1);
    check("rdiv.3.done", done, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);                   // T+4
    check("rdiv.4.busy", busy, 1'b0);
    check("rdiv.4.done", done, 1'b0);
    cyc(4'd1, 1'b0, 1'b0, 1'b0);                   // T+5 MULT
    check("rdiv.5.start", start,    1'b1);
    check("rdiv.5.ctrl",  mdu_ctrl, 4'd1);
    check("rdiv.5.done",  done,     1'b0);
    for (int k = 6; k <= 11; k++) begin
      cyc(4'd0, 1'b0, 1'b0, 1'b0);
      check($sformatf("rdiv.%0d.busy", k), busy, (k <= 10));
      check($sformatf("rdiv.%0d.done", k), done, (k == 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
